// File: rtl/gb_bus_sync.sv
// gb_bus_sync: syncs the async GB cartridge bus into clk and emits one clean wr_stb per qualified write; GB_BUS_GLITCH_CNT_EN adds glitch_cnt.
// Latency: wr_stb SYNC_STAGES+FILTER_CYCLES+1 edges after gb_write_n is first sampled low; no backpressure (the GB bus cannot be stalled).
module gb_bus_sync #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int DATA_W        = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              gb_write_n,
    input  logic              gb_read_n,
    input  logic              gb_rst_n,
    input  logic [2:0]        gb_addr_hi,
    input  logic [DATA_W-1:0] gb_data,
    output logic              wr_stb,
    output logic [2:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_active,
    output logic              gb_rst_n_sync,
    output logic              bus_conflict
`ifdef GB_BUS_GLITCH_CNT_EN
    ,
    output logic [7:0]        glitch_cnt
`endif
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_QUAL    = 2'd1;
    localparam logic [1:0] ST_STROBE  = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;
    localparam logic [3:0] FILT       = 4'(FILTER_CYCLES);

    logic [SYNC_STAGES-1:0]             r_sw_pipe;
    logic [SYNC_STAGES-1:0]             r_sr_pipe;
    logic [SYNC_STAGES-1:0]             r_sg_pipe;
    logic [SYNC_STAGES-1:0][2:0]        r_sa_pipe;
    logic [SYNC_STAGES-1:0][DATA_W-1:0] r_sd_pipe;

    logic              w_sw, w_sr, w_sg;
    logic [2:0]        w_sa;
    logic [DATA_W-1:0] w_sd;
    logic              w_stable;

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic [2:0]        r_sh_addr;
    logic [DATA_W-1:0] r_sh_data;
    logic              r_wr_stb;
    logic [2:0]        r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_rd_active;
    logic              r_conflict;

    // Strobes and GB reset idle high so a reset never looks like bus activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_pipe <= '1;
            r_sr_pipe <= '1;
            r_sg_pipe <= '1;
            r_sa_pipe <= '0;
            r_sd_pipe <= '0;
        end else begin
            r_sw_pipe <= {r_sw_pipe[SYNC_STAGES-2:0], gb_write_n};
            r_sr_pipe <= {r_sr_pipe[SYNC_STAGES-2:0], gb_read_n};
            r_sg_pipe <= {r_sg_pipe[SYNC_STAGES-2:0], gb_rst_n};
            r_sa_pipe <= {r_sa_pipe[SYNC_STAGES-2:0], gb_addr_hi};
            r_sd_pipe <= {r_sd_pipe[SYNC_STAGES-2:0], gb_data};
        end
    end

    assign w_sw     = r_sw_pipe[SYNC_STAGES-1];
    assign w_sr     = r_sr_pipe[SYNC_STAGES-1];
    assign w_sg     = r_sg_pipe[SYNC_STAGES-1];
    assign w_sa     = r_sa_pipe[SYNC_STAGES-1];
    assign w_sd     = r_sd_pipe[SYNC_STAGES-1];
    assign w_stable = (w_sa == r_sh_addr) && (w_sd == r_sh_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_sh_addr   <= '0;
            r_sh_data   <= '0;
            r_wr_stb    <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_rd_active <= 1'b0;
            r_conflict  <= 1'b0;
        end else begin
            r_rd_active <= ~w_sr & w_sw;
            r_wr_stb    <= 1'b0;

            if (!w_sg) begin
                r_conflict <= 1'b0;
            end else if (!w_sw && !w_sr) begin
                r_conflict <= 1'b1;
            end

            // GB reset overrides every state, including a pending strobe.
            if (!w_sg) begin
                r_state <= ST_IDLE;
                r_cnt   <= 4'd0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_sw && w_sr) begin
                            r_state   <= ST_QUAL;
                            r_cnt     <= 4'd1;
                            r_sh_addr <= w_sa;
                            r_sh_data <= w_sd;
                        end
                    end
                    ST_QUAL: begin
                        if (w_sw || !w_sr) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= 4'd0;
                        end else if (!w_stable) begin
                            r_sh_addr <= w_sa;
                            r_sh_data <= w_sd;
                            r_cnt     <= 4'd1;
                        end else if (r_cnt == FILT) begin
                            r_state   <= ST_STROBE;
                            r_cnt     <= 4'd0;
                            r_wr_addr <= r_sh_addr;
                            r_wr_data <= r_sh_data;
                        end else if (r_cnt != 4'hF) begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    ST_STROBE: begin
                        r_wr_stb <= 1'b1;
                        r_state  <= ST_RELEASE;
                    end
                    ST_RELEASE: begin
                        if (w_sw) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef GB_BUS_GLITCH_CNT_EN
    logic [7:0] r_glitch_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_glitch_cnt <= 8'd0;
        end else if (w_sg && (r_state == ST_QUAL) && w_sw && (r_glitch_cnt != 8'hFF)) begin
            r_glitch_cnt <= r_glitch_cnt + 8'd1;
        end
    end

    assign glitch_cnt = r_glitch_cnt;
`endif

    assign wr_stb        = r_wr_stb;
    assign wr_addr       = r_wr_addr;
    assign wr_data       = r_wr_data;
    assign rd_active     = r_rd_active;
    assign gb_rst_n_sync = w_sg;
    assign bus_conflict  = r_conflict;

endmodule

// File: tb/tb_gb_bus_sync.sv
// Scoreboard bench for gb_bus_sync: a run-length reference model predicts strobes and levels, a negedge monitor compares.
module tb_gb_bus_sync;

    localparam int SYNC = 2;
    localparam int FILT = 4;
    localparam int DW   = 5;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          gb_write_n = 1'b1;
    logic          gb_read_n  = 1'b1;
    logic          gb_rst_n   = 1'b1;
    logic [2:0]    gb_addr_hi = 3'd0;
    logic [DW-1:0] gb_data    = '0;
    logic          wr_stb;
    logic [2:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_active;
    logic          gb_rst_n_sync;
    logic          bus_conflict;
`ifdef GB_BUS_GLITCH_CNT_EN
    logic [7:0]    glitch_cnt;
`endif

    gb_bus_sync #(.SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .gb_write_n   (gb_write_n),
        .gb_read_n    (gb_read_n),
        .gb_rst_n     (gb_rst_n),
        .gb_addr_hi   (gb_addr_hi),
        .gb_data      (gb_data),
        .wr_stb       (wr_stb),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_active    (rd_active),
        .gb_rst_n_sync(gb_rst_n_sync),
        .bus_conflict (bus_conflict)
`ifdef GB_BUS_GLITCH_CNT_EN
        ,
        .glitch_cnt   (glitch_cnt)
`endif
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int            cyc;
        logic [2:0]    a;
        logic [DW-1:0] d;
    } exp_t;
    exp_t sb[$];

    // Reference model: inputs seen by the filter are those sampled SYNC edges ago;
    // a write fires once (addr,data) has been seen unchanged for FILT+1 consecutive
    // low-write/high-read cycles, and the pulse appears one edge after that decision.
    bit            h_w[SYNC], h_r[SYNC], h_g[SYNC];
    logic [2:0]    h_a[SYNC];
    logic [DW-1:0] h_d[SYNC];
    bit            m_sw, m_sr, m_sg;
    logic [2:0]    m_sa, m_cur_a, m_cap_a;
    logic [DW-1:0] m_sd, m_cur_d, m_cap_d;
    int            m_run = 0;
    bit            m_pending = 0, m_rel = 0;
    bit            exp_rd = 0, exp_conf = 0, exp_sg = 1;
    int            exp_glitch = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < SYNC; j++) begin
                h_w[j] = 1'b1; h_r[j] = 1'b1; h_g[j] = 1'b1; h_a[j] = '0; h_d[j] = '0;
            end
            m_run = 0; m_pending = 0; m_rel = 0;
            m_cur_a = '0; m_cur_d = '0;
            exp_rd = 0; exp_conf = 0; exp_sg = 1; exp_glitch = 0;
            sb.delete();
        end else begin
            m_sw = h_w[SYNC-1]; m_sr = h_r[SYNC-1]; m_sg = h_g[SYNC-1];
            m_sa = h_a[SYNC-1]; m_sd = h_d[SYNC-1];
            exp_rd = !m_sr && m_sw;
            if (!m_sg) exp_conf = 0;
            else if (!m_sw && !m_sr) exp_conf = 1;

            if (m_pending) begin
                m_pending = 0;
                if (m_sg) sb.push_back('{cyc + 1, m_cap_a, m_cap_d});
                m_rel = m_sg;
                m_run = 0;
            end else if (!m_sg) begin
                m_run = 0;
                m_rel = 0;
            end else if (m_rel) begin
                if (m_sw) m_rel = 0;
            end else if (!m_sw && m_sr) begin
                if (m_run > 0 && m_sa == m_cur_a && m_sd == m_cur_d) begin
                    m_run++;
                end else begin
                    m_cur_a = m_sa; m_cur_d = m_sd; m_run = 1;
                end
                if (m_run == FILT + 1) begin
                    m_pending = 1; m_cap_a = m_cur_a; m_cap_d = m_cur_d; m_run = 0;
                end
            end else begin
                if (m_sw && m_run > 0 && exp_glitch < 255) exp_glitch++;
                m_run = 0;
            end

            for (int j = SYNC - 1; j > 0; j--) begin
                h_w[j] = h_w[j-1]; h_r[j] = h_r[j-1]; h_g[j] = h_g[j-1];
                h_a[j] = h_a[j-1]; h_d[j] = h_d[j-1];
            end
            h_w[0] = gb_write_n; h_r[0] = gb_read_n; h_g[0] = gb_rst_n;
            h_a[0] = gb_addr_hi; h_d[0] = gb_data;
            exp_sg = h_g[SYNC-1];
        end
    end

    int            stb_count = 0;
    logic [2:0]    last_a = '0;
    logic [DW-1:0] last_d = '0;
    exp_t          mon_e;

    always @(negedge clk) begin
        if (wr_stb) begin
            stb_count++;
            last_a = wr_addr;
            last_d = wr_data;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_stb: got strobe addr=%0d data=%0h at cycle %0d, required none", wr_addr, wr_data, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("stb_cycle", cyc, mon_e.cyc);
                chk("stb_addr", int'(wr_addr), int'(mon_e.a));
                chk("stb_data", int'(wr_data), int'(mon_e.d));
            end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            tests++;
            fails++;
            $display("FAIL missing_stb: got no strobe at cycle %0d, required addr=%0d data=%0h", mon_e.cyc, mon_e.a, mon_e.d);
        end
        chk("rd_active", int'(rd_active), int'(exp_rd));
        chk("bus_conflict", int'(bus_conflict), int'(exp_conf));
        chk("gb_rst_n_sync", int'(gb_rst_n_sync), int'(exp_sg));
`ifdef GB_BUS_GLITCH_CNT_EN
        chk("glitch_cnt", int'(glitch_cnt), exp_glitch);
`endif
    end

    task automatic hold(input int n, output int first);
        first = -1;
        repeat (n) begin
            @(negedge clk);
            if (wr_stb && first < 0) first = cyc;
        end
    endtask

    task automatic go_idle();
        gb_write_n = 1'b1;
        gb_read_n  = 1'b1;
        gb_rst_n   = 1'b1;
    endtask

    int t0, s0, f1, f2, dummy, k, len, r1;

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_wr_stb", int'(wr_stb), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_rd_active", int'(rd_active), 0);
        chk("rst_bus_conflict", int'(bus_conflict), 0);
        chk("rst_gb_rst_n_sync", int'(gb_rst_n_sync), 1);
        rst_n = 1'b1;

        // Clean write
        @(negedge clk);
        gb_addr_hi = 3'b001; gb_data = 5'h13; gb_write_n = 1'b0;
        t0 = cyc + 1; s0 = stb_count;
        hold(25, f1);
        gb_write_n = 1'b1;
        hold(10, dummy);
        chk("clean_latency", f1 - t0, 7);
        chk("clean_count", stb_count - s0, 1);
        chk("clean_addr", int'(last_a), 1);
        chk("clean_data", int'(last_d), 'h13);

        // Short glitch
        s0 = stb_count;
        gb_addr_hi = 3'b011; gb_data = 5'h07; gb_write_n = 1'b0;
        hold(3, dummy);
        gb_write_n = 1'b1;
        hold(12, dummy);
        chk("glitch_count", stb_count - s0, 0);
`ifdef GB_BUS_GLITCH_CNT_EN
        chk("glitch_cnt_one", int'(glitch_cnt), 1);
`endif

        // Data change on the second qualification cycle restarts the filter
        s0 = stb_count;
        gb_addr_hi = 3'b010; gb_data = 5'h0A; gb_write_n = 1'b0;
        t0 = cyc + 1;
        hold(2, f1);
        gb_data = 5'h05;
        hold(20, f2);
        gb_write_n = 1'b1;
        hold(10, dummy);
        chk("restart_latency", ((f1 >= 0) ? f1 : f2) - t0, 9);
        chk("restart_count", stb_count - s0, 1);
        chk("restart_data", int'(last_d), 5);

        // Long-held write then a second write
        s0 = stb_count;
        gb_addr_hi = 3'b011; gb_data = 5'h11; gb_write_n = 1'b0;
        hold(200, dummy);
        gb_write_n = 1'b1;
        hold(10, dummy);
        gb_addr_hi = 3'b110; gb_data = 5'h02; gb_write_n = 1'b0;
        hold(20, dummy);
        gb_write_n = 1'b1;
        hold(10, dummy);
        chk("held_count", stb_count - s0, 2);
        chk("held_data", int'(last_d), 2);
        chk("held_addr", int'(last_a), 6);

        // Plain read, then read/write conflict cleared by GB reset
        gb_read_n = 1'b0;
        hold(6, dummy);
        chk("read_active", int'(rd_active), 1);
        gb_read_n = 1'b1;
        hold(5, dummy);
        chk("read_done", int'(rd_active), 0);
        s0 = stb_count;
        gb_read_n = 1'b0; gb_write_n = 1'b0;
        hold(10, dummy);
        go_idle();
        hold(5, dummy);
        chk("conflict_set", int'(bus_conflict), 1);
        chk("conflict_no_stb", stb_count - s0, 0);
        gb_rst_n = 1'b0;
        hold(4, dummy);
        gb_rst_n = 1'b1;
        hold(6, dummy);
        chk("conflict_clr", int'(bus_conflict), 0);

        // rst_n in the middle of qualification
        gb_addr_hi = 3'b101; gb_data = 5'h1F; gb_write_n = 1'b0;
        hold(5, dummy);
        #5 rst_n = 1'b0;
        #1;
        chk("midrst_wr_stb", int'(wr_stb), 0);
        chk("midrst_wr_addr", int'(wr_addr), 0);
        chk("midrst_wr_data", int'(wr_data), 0);
        chk("midrst_rd_active", int'(rd_active), 0);
        chk("midrst_conflict", int'(bus_conflict), 0);
        s0 = stb_count;
        @(negedge clk);
        #5 rst_n = 1'b1;
        t0 = cyc + 1;
        hold(20, f1);
        gb_write_n = 1'b1;
        hold(10, dummy);
        chk("midrst_latency", f1 - t0, 7);
        chk("midrst_count", stb_count - s0, 1);
        chk("midrst_data", int'(last_d), 'h1F);

        // Randomized traffic against the model
        repeat (60) begin
            k = $urandom_range(0, 9);
            gb_addr_hi = 3'($urandom_range(0, 7));
            gb_data    = DW'($urandom_range(0, 31));
            case (k)
                6: begin
                    gb_read_n = 1'b0;
                    hold($urandom_range(1, 10), dummy);
                end
                7: begin
                    gb_read_n = 1'b0; gb_write_n = 1'b0;
                    hold($urandom_range(1, 6), dummy);
                end
                8: begin
                    gb_rst_n = 1'b0;
                    hold($urandom_range(1, 4), dummy);
                end
                9: begin
                    gb_write_n = 1'b0;
                    r1 = $urandom_range(1, 10);
                    hold(r1, dummy);
                    gb_rst_n = 1'b0;
                    hold($urandom_range(1, 3), dummy);
                    gb_rst_n = 1'b1;
                    hold($urandom_range(1, 12), dummy);
                end
                default: begin
                    len = $urandom_range(1, 16);
                    gb_write_n = 1'b0;
                    hold(len, dummy);
                    if (k == 5) begin
                        gb_data = gb_data ^ DW'($urandom_range(1, 31));
                        hold($urandom_range(1, 12), dummy);
                    end
                end
            endcase
            go_idle();
            hold($urandom_range(3, 8), dummy);
        end
        hold(20, dummy);
        chk("sb_drain", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
